// File: rtl/bp_pkg.sv
// Types and helpers shared by the fetch-side predictor and the MEM-stage
// counter-update logic.
package bp_pkg;

    // 2-bit saturating branch counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } counter_t;

    // Value every PHT entry holds after the init sweep.
    localparam counter_t CTR_RESET = WN;

    // Larger of two widths, used to size the shared init sweep counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Saturating counter step on a resolved outcome (used by the MEM stage).
    function automatic counter_t ctr_next(input counter_t c, input logic taken);
        counter_t n;
        n = c;
        case (c)
            SN: n = taken ? WN : SN;
            WN: n = taken ? WT : SN;
            WT: n = taken ? ST : WN;
            ST: n = taken ? ST : WT;
            default: n = CTR_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bp_table_ram.sv
// Small register-file table used for both the BHT and the PHT.
// The main read port is write-first: a write in the same cycle to the
// address being read is forwarded. A second, raw read port returns the
// stored contents without forwarding, for read-modify-write of an entry
// (forwarding there would loop the written data back into itself).
module bp_table_ram #(
    parameter int WIDTH  = 2,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    input  logic [ADDR_W-1:0] raw_addr,
    output logic [WIDTH-1:0]  raw_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are initialised by the owner's sweep, not by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data  = (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    assign raw_data = mem[raw_addr];

endmodule

// File: rtl/local_branch_predictor.sv
// Fetch-side lookup of the local two-level predictor. Per-PC history from
// the BHT selects a 2-bit counter in the PHT; the result is registered for
// IF. MEM writes back the shifted history and the new counter. After reset
// the block sweeps both tables to their initial values before going ready.
module local_branch_predictor
    import bp_pkg::*;
#(
    parameter int BHT_IDX_W = 5,
    parameter int HIST_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_read_en,
    input  logic [31:0]       if_pc,
    output logic              pred_valid,
    output logic [1:0]        pred_counter,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_hist,
    output logic              ready,
    input  logic              mem_load,
    input  logic [31:0]       mem_pc,
    input  logic [HIST_W-1:0] mem_hist,
    input  logic              mem_actual,
    input  logic [1:0]        mem_updated_prediction
);

    localparam int CNT_W = max_int(BHT_IDX_W, HIST_W);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] sweep_cnt;

    logic [BHT_IDX_W-1:0] if_idx;
    logic [BHT_IDX_W-1:0] mem_idx;

    // BHT signals
    logic                 bht_we;
    logic [BHT_IDX_W-1:0] bht_wa;
    logic [HIST_W-1:0]    bht_wd;
    logic [HIST_W-1:0]    old_hist;
    logic [HIST_W-1:0]    new_hist;
    logic [HIST_W-1:0]    lookup_hist;

    // PHT signals
    logic              pht_we;
    logic [HIST_W-1:0] pht_wa;
    logic [1:0]        pht_wd;
    logic [1:0]        lookup_ctr;
    logic [1:0]        unused_pht_raw;

    logic sweep_in_bht;
    logic sweep_in_pht;
    logic unused_pc_bits;

    assign if_idx   = if_pc[BHT_IDX_W+1:2];
    assign mem_idx  = mem_pc[BHT_IDX_W+1:2];
    assign new_hist = {old_hist[HIST_W-2:0], mem_actual};

    // The sweep counter spans the larger table; the smaller one stops early.
    assign sweep_in_bht = ((sweep_cnt >> BHT_IDX_W) == '0);
    assign sweep_in_pht = ((sweep_cnt >> HIST_W) == '0);

    assign unused_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0],
                              mem_pc[31:BHT_IDX_W+2], mem_pc[1:0]};

    // Table write-port steering: init sweep, MEM update, or nothing under reset.
    always_comb begin
        bht_we = 1'b0;
        bht_wa = mem_idx;
        bht_wd = new_hist;
        pht_we = 1'b0;
        pht_wa = mem_hist;
        pht_wd = mem_updated_prediction;
        if (!rst) begin
            if (state == INIT) begin
                bht_we = sweep_in_bht;
                bht_wa = sweep_cnt[BHT_IDX_W-1:0];
                bht_wd = '0;
                pht_we = sweep_in_pht;
                pht_wa = sweep_cnt[HIST_W-1:0];
                pht_wd = CTR_RESET;
            end else begin
                bht_we = mem_load;
                pht_we = mem_load;
            end
        end
    end

    // BHT: forwarded read serves the lookup, raw read feeds the history shift.
    bp_table_ram #(
        .WIDTH  (HIST_W),
        .ADDR_W (BHT_IDX_W)
    ) u_bht (
        .clk      (clk),
        .we       (bht_we),
        .wr_addr  (bht_wa),
        .wr_data  (bht_wd),
        .rd_addr  (if_idx),
        .rd_data  (lookup_hist),
        .raw_addr (mem_idx),
        .raw_data (old_hist)
    );

    // PHT: indexed by the (possibly forwarded) history, so both bypasses chain.
    bp_table_ram #(
        .WIDTH  (2),
        .ADDR_W (HIST_W)
    ) u_pht (
        .clk      (clk),
        .we       (pht_we),
        .wr_addr  (pht_wa),
        .wr_data  (pht_wd),
        .rd_addr  (lookup_hist),
        .rd_data  (lookup_ctr),
        .raw_addr (mem_hist),
        .raw_data (unused_pht_raw)
    );

    // INIT/READY FSM with sweep counter and registered lookup outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            sweep_cnt    <= '0;
            ready        <= 1'b0;
            pred_valid   <= 1'b0;
            pred_counter <= CTR_RESET;
            pred_hist    <= '0;
        end else begin
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == '1) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                READY: begin
                    if (if_read_en) begin
                        pred_valid   <= 1'b1;
                        pred_hist    <= lookup_hist;
                        pred_counter <= lookup_ctr;
                    end
                end
                default: begin
                    state     <= INIT;
                    sweep_cnt <= '0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

    assign pred_taken = pred_counter[1];

endmodule

// File: tb/tb_local_branch_predictor.sv
// Directed bench for local_branch_predictor: reset/init timing, a table of
// lookup/update vectors with hand-computed results, and a mid-operation
// reset followed by a full read-back of both tables.
module tb_local_branch_predictor;

    logic        clk;
    logic        rst;
    logic        if_read_en;
    logic [31:0] if_pc;
    logic        pred_valid;
    logic [1:0]  pred_counter;
    logic        pred_taken;
    logic [3:0]  pred_hist;
    logic        ready;
    logic        mem_load;
    logic [31:0] mem_pc;
    logic [3:0]  mem_hist;
    logic        mem_actual;
    logic [1:0]  mem_updated_prediction;

    int vec_count  = 0;
    int miscompares = 0;

    local_branch_predictor #(
        .BHT_IDX_W (5),
        .HIST_W    (4)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .if_read_en             (if_read_en),
        .if_pc                  (if_pc),
        .pred_valid             (pred_valid),
        .pred_counter           (pred_counter),
        .pred_taken             (pred_taken),
        .pred_hist              (pred_hist),
        .ready                  (ready),
        .mem_load               (mem_load),
        .mem_pc                 (mem_pc),
        .mem_hist               (mem_hist),
        .mem_actual             (mem_actual),
        .mem_updated_prediction (mem_updated_prediction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] pc;
        logic        ld;
        logic [31:0] mpc;
        logic [3:0]  mh;
        logic        act;
        logic [1:0]  upd;
        logic        ev;
        logic [1:0]  ec;
        logic        et;
        logic [3:0]  eh;
    } vec_t;

    vec_t vecs[20];

    task automatic check_out(input string nm, input logic ev, input logic [1:0] ec,
                             input logic et, input logic [3:0] eh);
        vec_count++;
        if ({pred_valid, pred_counter, pred_taken, pred_hist} !== {ev, ec, et, eh}) begin
            miscompares++;
            $display("FAIL %s: got valid=%0b ctr=%b taken=%0b hist=%b, want valid=%0b ctr=%b taken=%0b hist=%b",
                     nm, pred_valid, pred_counter, pred_taken, pred_hist, ev, ec, et, eh);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        vec_count++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", nm, got, exp);
        end
    endtask

    // Called at a negedge; drives one cycle of inputs, returns at the next negedge.
    task automatic step(input logic rd, input logic [31:0] pc, input logic ld,
                        input logic [31:0] mpc, input logic [3:0] mh,
                        input logic act, input logic [1:0] upd);
        if_read_en = rd;
        if_pc = pc;
        mem_load = ld;
        mem_pc = mpc;
        mem_hist = mh;
        mem_actual = act;
        mem_updated_prediction = upd;
        @(posedge clk);
        @(negedge clk);
        if_read_en = 1'b0;
        mem_load = 1'b0;
    endtask

    // Counts cycles until ready rises (bounded). With noisy set, hammers
    // lookups and updates that must all be ignored while initialising.
    task automatic wait_ready(input bit noisy, output int n);
        logic [31:0] kv;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            kv = k;
            if (noisy) begin
                if_read_en = 1'b1;
                if_pc = kv << 2;
                mem_load = 1'b1;
                mem_pc = (kv << 2) | 32'h40;
                mem_hist = kv[3:0];
                mem_actual = 1'b1;
                mem_updated_prediction = kv[0] ? 2'b11 : 2'b00;
            end
            @(posedge clk);
            @(negedge clk);
            if (noisy) begin
                vec_count++;
                if (pred_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL init_valid_low cycle %0d: got %0b, want 0", k, pred_valid);
                end
            end
            if (ready === 1'b1) begin
                n = k;
                break;
            end
        end
        if_read_en = 1'b0;
        mem_load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // rd pc ld mpc mh act upd | valid ctr taken hist
        vecs[0]  = '{1'b1, 32'h1000, 1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 4'b0000};
        vecs[1]  = '{1'b0, 32'h0,    1'b1, 32'h40, 4'h0, 1'b1, 2'b10, 1'b1, 2'b01, 1'b0, 4'b0000};
        vecs[2]  = '{1'b1, 32'h40,   1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 4'b0001};
        vecs[3]  = '{1'b1, 32'h44,   1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 4'b0000};
        vecs[4]  = '{1'b0, 32'h40,   1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 4'b0000};
        vecs[5]  = '{1'b0, 32'h80,   1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 4'b0000};
        vecs[6]  = '{1'b0, 32'h123C, 1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 4'b0000};
        vecs[7]  = '{1'b0, 32'h44,   1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 4'b0000};
        vecs[8]  = '{1'b0, 32'hFFC,  1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 4'b0000};
        vecs[9]  = '{1'b1, 32'h48,   1'b1, 32'h48, 4'h0, 1'b1, 2'b10, 1'b1, 2'b01, 1'b0, 4'b0001};
        vecs[10] = '{1'b1, 32'h4C,   1'b1, 32'h4C, 4'h1, 1'b1, 2'b11, 1'b1, 2'b11, 1'b1, 4'b0001};
        vecs[11] = '{1'b1, 32'h40,   1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b11, 1'b1, 4'b0001};
        vecs[12] = '{1'b1, 32'h1000, 1'b1, 32'h60, 4'h0, 1'b0, 2'b11, 1'b1, 2'b11, 1'b1, 4'b0000};
        vecs[13] = '{1'b0, 32'h0,    1'b1, 32'hC0, 4'h2, 1'b1, 2'b00, 1'b1, 2'b11, 1'b1, 4'b0000};
        vecs[14] = '{1'b1, 32'h40,   1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 4'b0011};
        vecs[15] = '{1'b1, 32'hC0,   1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 4'b0011};
        vecs[16] = '{1'b1, 32'h40,   1'b1, 32'h40, 4'h3, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 4'b0110};
        vecs[17] = '{1'b1, 32'h44,   1'b0, 32'h0,  4'h0, 1'b0, 2'b00, 1'b1, 2'b11, 1'b1, 4'b0000};
        vecs[18] = '{1'b0, 32'h0,    1'b1, 32'h40, 4'h0, 1'b1, 2'b11, 1'b1, 2'b11, 1'b1, 4'b0000};
        vecs[19] = '{1'b1, 32'h40,   1'b1, 32'h40, 4'h0, 1'b1, 2'b11, 1'b1, 2'b01, 1'b0, 4'b1011};

        rst = 1'b1;
        if_read_en = 1'b0;
        if_pc = '0;
        mem_load = 1'b0;
        mem_pc = '0;
        mem_hist = '0;
        mem_actual = 1'b0;
        mem_updated_prediction = '0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_out("reset_outputs", 1'b0, 2'b01, 1'b0, 4'b0000);
        check_int("reset_ready", int'(ready), 0);
        rst = 1'b0;
        wait_ready(1'b0, n);
        check_int("init_length", n, 32);

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rd, vecs[i].pc, vecs[i].ld, vecs[i].mpc,
                 vecs[i].mh, vecs[i].act, vecs[i].upd);
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].et, vecs[i].eh);
        end

        // Single-cycle reset pulse carrying an update and a lookup
        rst = 1'b1;
        step(1'b1, 32'h40, 1'b1, 32'h44, 4'h0, 1'b1, 2'b00);
        rst = 1'b0;
        check_out("pulse_outputs", 1'b0, 2'b01, 1'b0, 4'b0000);
        check_int("pulse_ready", int'(ready), 0);
        wait_ready(1'b1, n);
        check_int("reinit_length", n, 32);

        // Every BHT entry reads back zero history (and PHT[0] is WN)
        for (int i = 0; i < 32; i++) begin
            logic [31:0] pcv;
            pcv = i;
            step(1'b1, pcv << 2, 1'b0, 32'h0, 4'h0, 1'b0, 2'b00);
            check_out($sformatf("bht_init%0d", i), 1'b1, 2'b01, 1'b0, 4'b0000);
        end

        // Every PHT entry reads WN: steer BHT[1] to each history value first
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kb;
            kb = k;
            for (int b = 3; b >= 0; b--) begin
                step(1'b0, 32'h0, 1'b1, 32'h4, 4'hF, kb[b], 2'b01);
            end
            step(1'b1, 32'h4, 1'b0, 32'h0, 4'h0, 1'b0, 2'b00);
            check_out($sformatf("pht_init%0d", k), 1'b1, 2'b01, 1'b0, kb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
